mtx_res_collector: RTL and testbench

Gathers result streams from the NUM_CH mapu channels of the matrix sub-system and merges them into one tagged output stream. Arbitration is round-robin and packet-locked: once a channel is granted, it keeps the grant until it has sent its last beat. Accepted beats are buffered in an output FIFO. The block sits in mtx beside the mapu array, on the return path toward the sub-system egress.

---
 rtl/mtx_pkg.sv | 22 ++
 rtl/mtx_res_fifo.sv | 63 ++++++
 rtl/mtx_res_collector.sv | 143 ++++++++++++++
 tb/tb_mtx_res_collector.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtx_pkg.sv
// mtx_pkg: shared types and helpers for the mtx result-return path.
//   mtx_col_state_t : collector lock FSM states (IDLE, LOCKED)
//   mtx_ch_idx_w()  : channel index width, max(1, $clog2(n))
//   mtx_wrap()      : v mod n for 0 <= v < 2n, used by the round-robin search
package mtx_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } mtx_col_state_t;

    function automatic int mtx_ch_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Conditional subtract instead of a general modulo: the operand never
    // reaches 2n, so this stays a comparator plus subtractor.
    function automatic int mtx_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/mtx_res_fifo.sv
// mtx_res_fifo: first-word-fall-through FIFO.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din  : write request and data; ignored while full
//   pop, dout  : read request and head entry; dout is only meaningful when !empty
//   full/empty : derived from registered occupancy only
//   lvl        : registered occupancy, 0..DEPTH
module mtx_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   lvl
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      lvl_q, lvl_d;
    logic             do_push, do_pop;

    // Full does not look at this cycle's pop, so a pop never frees space
    // for a same-cycle push; this keeps ready off the output-side timing path.
    always_comb begin
        full     = (lvl_q == (AW+1)'(DEPTH));
        empty    = (lvl_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = do_push ? (wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + 1'b1) : rd_ptr_q;
        lvl_d    = lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
        end
    end

    // Storage carries no reset; stale entries are masked by empty upstream.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout = mem_q[rd_ptr_q];
    assign lvl  = lvl_q;

endmodule

// File: rtl/mtx_res_collector.sv
// mtx_res_collector: merges NUM_CH mapu result streams into one tagged stream.
//   sys_clk, sys_rst_n        : clock, synchronous active-low reset
//   ch_vld/ch_rdy/ch_data/ch_last : per-channel beat handshake (channel i at
//                               ch_data[i*DATA_WIDTH +: DATA_WIDTH])
//   out_vld/out_rdy/out_data/out_ch/out_last : merged FWFT output, tagged with
//                               the source channel
//   fifo_lvl                  : registered output FIFO occupancy
//   pkt_cnt                   : saturating count of packets popped at the output
// Arbitration is round-robin and packet-locked: a granted channel keeps the
// grant until its last beat is accepted, then one idle cycle re-arbitrates.
module mtx_res_collector
    import mtx_pkg::*;
#(
    parameter int NUM_CH     = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst_n,
    input  logic [NUM_CH-1:0]                 ch_vld,
    output logic [NUM_CH-1:0]                 ch_rdy,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      ch_data,
    input  logic [NUM_CH-1:0]                 ch_last,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [mtx_ch_idx_w(NUM_CH)-1:0]   out_ch,
    output logic                              out_last,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_lvl,
    output logic [CNT_WIDTH-1:0]              pkt_cnt
);
    localparam int CH_W  = mtx_ch_idx_w(NUM_CH);
    localparam int ENT_W = CH_W + 1 + DATA_WIDTH;

    mtx_col_state_t       state_q, state_d;
    logic [CH_W-1:0]      grant_q, grant_d;
    logic [CH_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [DATA_WIDTH-1:0] ch_data_a [NUM_CH];
    logic [CH_W-1:0]       cand_idx  [NUM_CH];
    logic                  arb_found;
    logic [CH_W-1:0]       arb_idx;

    logic                  sel_vld, sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  push, pop;
    logic                  fifo_full, fifo_empty;
    logic [ENT_W-1:0]      fifo_din, fifo_dout;

    // cand_idx[k] is the k-th channel visited when searching from rr_ptr.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_data_a[gi] = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
        assign cand_idx[gi]  = CH_W'(mtx_wrap(int'(rr_ptr_q) + gi, NUM_CH));
        assign ch_rdy[gi]    = (state_q == LOCKED) && (grant_q == CH_W'(gi)) && !fifo_full;
    end

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!arb_found && ch_vld[cand_idx[k]]) begin
                arb_found = 1'b1;
                arb_idx   = cand_idx[k];
            end
        end
    end

    assign sel_vld  = ch_vld[grant_q];
    assign sel_last = ch_last[grant_q];
    assign sel_data = ch_data_a[grant_q];
    assign push     = (state_q == LOCKED) && sel_vld && !fifo_full;
    assign fifo_din = {grant_q, sel_last, sel_data};

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (push && sel_last) begin
                    state_d  = IDLE;
                    rr_ptr_d = CH_W'(mtx_wrap(int'(grant_q) + 1, NUM_CH));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    mtx_res_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .lvl   (fifo_lvl)
    );

    // Head fields are forced to zero while empty so the RAM's undefined
    // contents never leak onto the output bus.
    assign out_vld  = !fifo_empty;
    assign out_data = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
    assign out_last = fifo_empty ? 1'b0 : fifo_dout[DATA_WIDTH];
    assign out_ch   = fifo_empty ? '0 : fifo_dout[ENT_W-1 -: CH_W];
    assign pop      = out_vld && out_rdy;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (pop && out_last && (pkt_cnt_q != {CNT_WIDTH{1'b1}})) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_mtx_res_collector.sv
// tb_mtx_res_collector: scoreboard bench for mtx_res_collector.
// Main thread stages packets per channel; commit() orders them with a
// packet-level round-robin model and pushes the expected output beats.
// A driver process plays the per-channel producers, a monitor process pops
// and compares every output beat and the saturating packet count.
module tb_mtx_res_collector;
    localparam int NUM_CH = 32;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int CW     = 4;
    localparam int CH_W   = 5;
    localparam int LVL_W  = 3;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        int            ch;
        logic          last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_CH-1:0]    ch_vld, ch_rdy, ch_last;
    logic [NUM_CH*DW-1:0] ch_data;
    logic                 out_vld, out_rdy, out_last;
    logic [DW-1:0]        out_data;
    logic [CH_W-1:0]      out_ch;
    logic [LVL_W-1:0]     fifo_lvl;
    logic [CW-1:0]        pkt_cnt;

    beat_t  chq [NUM_CH][$];   // written by main, consumed by driver via drv_idx
    beat_t  stg [NUM_CH][$];   // main-only staging
    int     drv_idx [NUM_CH];
    exp_t   expq [$];          // written by main, consumed by monitor via rd_idx
    int     rd_idx;
    int     model_ptr;
    bit     gaps_en;
    bit     gap_chk;
    int     n_checks = 0;
    int     n_pass   = 0;
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mtx_res_collector #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .ch_vld    (ch_vld),
        .ch_rdy    (ch_rdy),
        .ch_data   (ch_data),
        .ch_last   (ch_last),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .fifo_lvl  (fifo_lvl),
        .pkt_cnt   (pkt_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    // Producers: hold each beat until accepted; optionally idle between
    // beats of a packet already under grant (never before a packet's first beat).
    initial begin : driver
        logic [NUM_CH-1:0] acc;
        bit                mid [NUM_CH];
        ch_vld = '0; ch_last = '0; ch_data = '0; acc = '0;
        for (int i = 0; i < NUM_CH; i++) begin drv_idx[i] = 0; mid[i] = 0; end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!rst_n) begin
                    drv_idx[i] = chq[i].size();
                    mid[i]     = 0;
                    ch_vld[i]  = 1'b0;
                end else begin
                    if (acc[i]) begin
                        mid[i]    = !chq[i][drv_idx[i]].last;
                        drv_idx[i]++;
                        ch_vld[i] = 1'b0;
                    end
                    if (!ch_vld[i] && drv_idx[i] < chq[i].size()) begin
                        if (!(mid[i] && gaps_en && $urandom_range(2) == 0)) begin
                            ch_vld[i]           = 1'b1;
                            ch_data[i*DW +: DW] = chq[i][drv_idx[i]].data;
                            ch_last[i]          = chq[i][drv_idx[i]].last;
                        end
                    end
                end
            end
            @(negedge clk);
            acc = ch_vld & ch_rdy;
        end
    end

    initial begin : monitor
        int     exp_cnt;
        longint last_pop;
        bit     have_prev;
        exp_t   e;
        exp_cnt = 0; rd_idx = 0; last_pop = 0; have_prev = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                rd_idx = expq.size(); exp_cnt = 0; have_prev = 0;
            end
            @(negedge clk);
            if (!gap_chk) have_prev = 0;
            if (rst_n && out_vld && out_rdy) begin
                $display("pop t=%0d ch=%0d data=0x%0h last=%0d cnt=%0d", cyc, out_ch, out_data, out_last, pkt_cnt);
                if (rd_idx >= expq.size()) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got ch=%0d data=0x%0h required no beat", out_ch, out_data);
                end else begin
                    e = expq[rd_idx];
                    rd_idx++;
                    chk("beat_data", out_data, e.data);
                    chk("beat_ch", out_ch, e.ch);
                    chk("beat_last", out_last, e.last);
                end
                chk("pkt_cnt", pkt_cnt, exp_cnt);
                if (out_last && exp_cnt < (1 << CW) - 1) exp_cnt++;
                if (gap_chk && have_prev) chk("grant_gap", cyc - last_pop, 2);
                last_pop  = cyc;
                have_prev = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic add_pkt(input int ch, input int len, input logic [DW-1:0] base);
        beat_t t;
        for (int b = 0; b < len; b++) begin
            t.data = base + DW'(b);
            t.last = (b == len - 1);
            stg[ch].push_back(t);
        end
    endtask

    // Packet-level round robin: every staged channel requests at once, the
    // next packet comes from the first staged channel at or after the pointer.
    task automatic commit();
        int    c;
        beat_t t;
        exp_t  e;
        forever begin
            c = -1;
            for (int k = 0; k < NUM_CH; k++)
                if (c < 0 && stg[(model_ptr + k) % NUM_CH].size() > 0) c = (model_ptr + k) % NUM_CH;
            if (c < 0) break;
            do begin
                t = stg[c].pop_front();
                e.data = t.data; e.ch = c; e.last = t.last;
                expq.push_back(e);
                chq[c].push_back(t);
            end while (!t.last);
            model_ptr = (c + 1) % NUM_CH;
        end
    endtask

    task automatic drain(input bit rand_rdy);
        int n;
        n = 0;
        while (rd_idx < expq.size() && n < 3000) begin
            out_rdy = rand_rdy ? ($urandom_range(3) != 0) : 1'b1;
            tick();
            n++;
        end
        out_rdy = 1'b1;
        chk("drain_timeout", (rd_idx < expq.size()), 0);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        model_ptr = 0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        out_rdy = 1'b1; gaps_en = 0; gap_chk = 0; model_ptr = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_ch_rdy", ch_rdy, 0);
        chk("rst_fifo_lvl", fifo_lvl, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_last", out_last, 0);
        rst_n = 1'b1;

        // 1: single 4-beat packet on ch3, latency from vld rise
        tick();
        add_pkt(3, 4, 32'h10);
        commit();
        @(negedge clk);
        @(negedge clk); chk("t1_lat_c0", out_vld, 0);
        @(negedge clk); chk("t1_rdy3", ch_rdy[3], 1); chk("t1_lat_c1", out_vld, 0);
        @(negedge clk); chk("t1_lat_c2", out_vld, 1);
        drain(0);
        chk("t1_pkt_cnt", pkt_cnt, 1);

        // 2: every channel one beat, ch0 twice -> 0..31 then 0, idle gap
        do_reset();
        gap_chk = 1;
        tick();
        for (int c = 0; c < NUM_CH; c++) add_pkt(c, 1, DW'(c));
        add_pkt(0, 1, 32'h100);
        commit();
        drain(0);
        gap_chk = 0;

        // 3: ch0 8-beat packet locks out a continuously requesting ch1
        do_reset();
        tick();
        add_pkt(0, 8, 32'h300);
        add_pkt(1, 2, 32'h310);
        add_pkt(1, 1, 32'h320);
        commit();
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (drv_idx[0] >= chq[0].size()) break;
            chk("t3_rdy1_locked_out", ch_rdy[1], 0);
        end
        chk("t3_ch0_done", (drv_idx[0] >= chq[0].size()), 1);
        drain(0);

        // 4: backpressure fills the FIFO
        tick();
        out_rdy = 1'b0;
        add_pkt(2, 6, 32'h400);
        commit();
        repeat (12) tick();
        chk("t4_lvl_full", fifo_lvl, DEPTH);
        chk("t4_rdy2_low", ch_rdy[2], 0);
        chk("t4_out_vld", out_vld, 1);
        drain(0);
        chk("t4_lvl_empty", fifo_lvl, 0);
        chk("t4_out_vld_end", out_vld, 0);

        // 5: reset mid-packet with three entries queued
        tick();
        out_rdy = 1'b0;
        add_pkt(2, 8, 32'h500);
        commit();
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (fifo_lvl == 3) break;
        end
        chk("t5_lvl3", fifo_lvl, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_out_vld", out_vld, 0);
        chk("t5_fifo_lvl", fifo_lvl, 0);
        chk("t5_ch_rdy", ch_rdy, 0);
        chk("t5_pkt_cnt", pkt_cnt, 0);
        rst_n = 1'b1;
        model_ptr = 0;
        out_rdy = 1'b1;
        tick();
        add_pkt(25, 1, 32'h525);
        add_pkt(7, 2, 32'h507);
        add_pkt(12, 1, 32'h512);
        commit();
        drain(0);

        // 6: counter saturation
        do_reset();
        tick();
        for (int p = 0; p < 20; p++) add_pkt($urandom_range(NUM_CH - 1), 1, $urandom);
        commit();
        drain(1);
        chk("t6_pkt_cnt_sat", pkt_cnt, 15);

        // random batches with producer gaps and output backpressure
        gaps_en = 1;
        for (int r = 0; r < 6; r++) begin
            tick();
            for (int q = 0; q < 6; q++)
                add_pkt($urandom_range(NUM_CH - 1), $urandom_range(5, 1), $urandom);
            commit();
            drain(1);
        end
        chk("end_fifo_lvl", fifo_lvl, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
